// File: rtl/row_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : row_skew_feeder_pkg
// Brief    : FSM encodings and sizing helper shared by the row skew feeder.
// Revision : 1.0 - initial release
// ============================================================================
package row_skew_feeder_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // $clog2 that never returns zero, so a counter always has at least one bit
    function automatic int clog2_min1(input int value);
        int bits;
        bits = $clog2(value);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_skew_feeder_skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_delay_line
// Brief    : DEPTH-stage valid/data shift register that advances only on en.
// Revision : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]      valid_sr;
    logic [DATA_WIDTH-1:0] data_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_sr[k] <= '0;
            end
        end else if (en) begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                valid_sr[k] <= valid_sr[k-1];
                data_sr[k]  <= data_sr[k-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : row_skew_feeder
// Brief    : Pops one tile of row vectors and feeds them to the array west
//            edge as a diagonal wavefront (lane i delayed by i cycles).
// Revision : 1.0 - initial release
// ============================================================================
module row_skew_feeder
    import row_skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int TILE_LEN   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_start,
    input  logic                            i_stall,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
    output logic [NUM_LANES-1:0]            o_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] o_data,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int ACC_W = $clog2(TILE_LEN + 1);
    localparam int DRN_W = clog2_min1(NUM_LANES);

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(TILE_LEN - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((NUM_LANES >= 2) ? NUM_LANES - 2 : 0);

    state_t           state;
    logic [ACC_W-1:0] accept_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             advance;
    logic             accept;

    assign advance = ~i_stall;
    assign s_ready = (state == FEED) & ~i_stall;
    assign accept  = s_valid & s_ready;
    assign o_busy  = (state != IDLE);
    assign o_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            accept_cnt <= '0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= FEED;
                        accept_cnt <= '0;
                        drain_cnt  <= '0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        accept_cnt <= accept_cnt + 1'b1;
                        // A single lane has no skew to flush, so skip DRAIN
                        if (accept_cnt == ACC_LAST) begin
                            state <= (NUM_LANES == 1) ? DONE : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (drain_cnt == DRN_LAST) begin
                            state <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bubbles carry zero data, so invalid lanes always present zero
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;

        assign lane_in = accept ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_line (
            .clk       (clk),
            .reset     (reset),
            .en        (advance),
            .in_valid  (accept),
            .in_data   (lane_in),
            .out_valid (o_valid[i]),
            .out_data  (o_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_skew_feeder
// Brief    : Directed self-checking bench for row_skew_feeder (4 lanes x 3
//            vectors) plus a 1-lane / 1-vector edge instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_skew_feeder;

    localparam int DW   = 8;
    localparam int NL   = 4;
    localparam int TL   = 3;
    localparam int NCYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               i_start;
    logic               i_stall;
    logic               s_valid;
    logic               s_ready;
    logic [NL*DW-1:0]   s_data;
    logic [NL-1:0]      o_valid;
    logic [NL*DW-1:0]   o_data;
    logic               o_busy;
    logic               o_done;

    logic               e_start;
    logic               e_stall;
    logic               e_svalid;
    logic               e_sready;
    logic [DW-1:0]      e_sdata;
    logic [0:0]         e_ovalid;
    logic [DW-1:0]      e_odata;
    logic               e_busy;
    logic               e_done;

    row_skew_feeder #(.DATA_WIDTH(DW), .NUM_LANES(NL), .TILE_LEN(TL)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_stall (i_stall),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    row_skew_feeder #(.DATA_WIDTH(DW), .NUM_LANES(1), .TILE_LEN(1)) u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_start (e_start),
        .i_stall (e_stall),
        .s_valid (e_svalid),
        .s_ready (e_sready),
        .s_data  (e_sdata),
        .o_valid (e_ovalid),
        .o_data  (e_odata),
        .o_busy  (e_busy),
        .o_done  (e_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    logic [NL*DW-1:0] vecs   [0:15];
    logic [NL-1:0]    lv     [0:NCYC-1];
    logic [NL*DW-1:0] ld     [0:NCYC-1];
    logic             rdy    [0:NCYC-1];
    logic             acc_l  [0:NCYC-1];
    logic             done_l [0:NCYC-1];
    logic             busy_l [0:NCYC-1];
    int               n_acc;
    int               n_done;

    function automatic logic [DW-1:0] lane(input int c, input int i);
        return ld[c][i*DW +: DW];
    endfunction

    // Cycle 0 is the i_start cycle; the log holds what the DUT shows in each cycle
    task automatic run_tile(input int gap_len, input int stall_from, input int stall_len,
                            input int vhold, input int nvec, input int rst_at);
        int vec_idx;
        int gap_left;
        vec_idx  = 0;
        gap_left = 0;
        n_acc    = 0;
        n_done   = 0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        i_start = 1'b1;
        i_stall = 1'b0;
        s_valid = (vhold > 0);
        s_data  = vecs[0];
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            lv[c]     = o_valid;
            ld[c]     = o_data;
            rdy[c]    = s_ready;
            busy_l[c] = o_busy;
            done_l[c] = o_done;
            acc_l[c]  = s_valid & s_ready & ~reset;
            if (acc_l[c]) begin
                n_acc++;
                vec_idx++;
                if (vec_idx == 1) gap_left = gap_len;
            end
            if (o_done) n_done++;
            @(posedge clk);
            #1;
            i_start = 1'b0;
            reset   = (c + 1 == rst_at);
            i_stall = (c + 1 >= stall_from) && (c + 1 < stall_from + stall_len);
            if (gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else begin
                s_valid = (c + 1 < vhold) && (vec_idx < nvec);
            end
            s_data = vecs[vec_idx & 15];
        end
    endtask

    logic          e_acc_l  [0:7];
    logic          e_v_l    [0:7];
    logic [DW-1:0] e_d_l    [0:7];
    logic          e_done_l [0:7];
    logic          e_busy_l [0:7];
    int            e_nacc;
    int            e_ndone;

    initial begin
        vecs[0] = 32'h0403_0201;
        vecs[1] = 32'h1413_1211;
        vecs[2] = 32'h2423_2221;
        for (int k = 3; k < 16; k++) vecs[k] = 32'hEE00_0000 | 32'(k);

        reset    = 1'b1;
        i_start  = 1'b0;
        i_stall  = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        e_start  = 1'b0;
        e_stall  = 1'b0;
        e_svalid = 1'b0;
        e_sdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_o_valid", o_valid, 0);
        check_val("rst_o_data",  o_data,  0);
        check_val("rst_o_busy",  o_busy,  0);
        check_val("rst_o_done",  o_done,  0);
        check_val("rst_e_valid", e_ovalid, 0);

        // Basic skew
        run_tile(0, 0, 0, NCYC, 3, -1);
        check_val("t1_accepts",  n_acc, 3);
        check_val("t1_busy_c0",  busy_l[0], 0);
        check_val("t1_busy_c1",  busy_l[1], 1);
        check_val("t1_l0_c2",    lane(2, 0), 8'h01);
        check_val("t1_l0_c3",    lane(3, 0), 8'h11);
        check_val("t1_l0_c4",    lane(4, 0), 8'h21);
        check_val("t1_l0v_c5",   lv[5][0], 0);
        check_val("t1_l0d_c5",   lane(5, 0), 8'h00);
        check_val("t1_l3v_c4",   lv[4][3], 0);
        check_val("t1_l3_c5",    lane(5, 3), 8'h04);
        check_val("t1_l3_c6",    lane(6, 3), 8'h14);
        check_val("t1_l3_c7",    lane(7, 3), 8'h24);
        check_val("t1_ready_c4", rdy[4], 0);
        check_val("t1_done_c7",  done_l[7], 1);
        check_val("t1_ndone",    n_done, 1);
        check_val("t1_busy_c8",  busy_l[8], 0);

        // FIFO bubble of two cycles after the first vector
        run_tile(2, 0, 0, NCYC, 3, -1);
        check_val("t2_accepts", n_acc, 3);
        check_val("t2_l0_c2",   lane(2, 0), 8'h01);
        check_val("t2_l0v_c3",  lv[3][0], 0);
        check_val("t2_l0v_c4",  lv[4][0], 0);
        check_val("t2_l0_c5",   lane(5, 0), 8'h11);
        check_val("t2_l0_c6",   lane(6, 0), 8'h21);
        check_val("t2_l3_c5",   lane(5, 3), 8'h04);
        check_val("t2_l3v_c7",  lv[7][3], 0);
        check_val("t2_l3_c8",   lane(8, 3), 8'h14);
        check_val("t2_l3_c9",   lane(9, 3), 8'h24);
        check_val("t2_done_c7", done_l[7], 0);
        check_val("t2_done_c9", done_l[9], 1);
        check_val("t2_ndone",   n_done, 1);

        // Three stall cycles in DRAIN
        run_tile(0, 5, 3, NCYC, 3, -1);
        check_val("t3_lv_c5",    lv[5], 4'b1110);
        check_val("t3_lv_c8",    lv[8], 4'b1110);
        check_val("t3_l1_c8",    lane(8, 1), 8'h22);
        check_val("t3_l3_c8",    lane(8, 3), 8'h04);
        check_val("t3_ready_c6", rdy[6], 0);
        check_val("t3_lv_c9",    lv[9], 4'b1100);
        check_val("t3_l3_c9",    lane(9, 3), 8'h14);
        check_val("t3_l3_c10",   lane(10, 3), 8'h24);
        check_val("t3_done_c7",  done_l[7], 0);
        check_val("t3_done_c10", done_l[10], 1);
        check_val("t3_ndone",    n_done, 1);

        // s_valid held high for ten cycles
        run_tile(0, 0, 0, 10, 16, -1);
        check_val("t4_accepts",  n_acc, 3);
        check_val("t4_ready_c3", rdy[3], 1);
        check_val("t4_ready_c4", rdy[4], 0);
        check_val("t4_acc_c4",   acc_l[4], 0);
        check_val("t4_done_c7",  done_l[7], 1);

        // Reset after two accepts, then a clean tile
        run_tile(0, 0, 0, NCYC, 3, 3);
        check_val("t5_accepts",  n_acc, 2);
        check_val("t5_lv_c4",    lv[4], 0);
        check_val("t5_ld_c4",    ld[4], 0);
        check_val("t5_ready_c4", rdy[4], 0);
        check_val("t5_busy_c4",  busy_l[4], 0);
        check_val("t5_ndone",    n_done, 0);
        run_tile(0, 0, 0, NCYC, 3, -1);
        check_val("t5b_accepts", n_acc, 3);
        check_val("t5b_l0_c2",   lane(2, 0), 8'h01);
        check_val("t5b_l3_c7",   lane(7, 3), 8'h24);
        check_val("t5b_done_c7", done_l[7], 1);

        // One lane, one vector; i_start held through FEED and DONE
        e_nacc  = 0;
        e_ndone = 0;
        @(posedge clk);
        #1;
        e_start  = 1'b1;
        e_svalid = 1'b1;
        e_sdata  = 8'hA5;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e_acc_l[c]  = e_svalid & e_sready;
            e_v_l[c]    = e_ovalid[0];
            e_d_l[c]    = e_odata;
            e_done_l[c] = e_done;
            e_busy_l[c] = e_busy;
            if (e_acc_l[c]) e_nacc++;
            if (e_done) e_ndone++;
            @(posedge clk);
            #1;
            e_start = (c + 1 <= 2);
            if (e_nacc > 0) e_sdata = 8'h5A;
        end
        check_val("t6_acc_c1",  e_acc_l[1], 1);
        check_val("t6_naccept", e_nacc, 1);
        check_val("t6_v_c1",    e_v_l[1], 0);
        check_val("t6_v_c2",    e_v_l[2], 1);
        check_val("t6_d_c2",    e_d_l[2], 8'hA5);
        check_val("t6_done_c2", e_done_l[2], 1);
        check_val("t6_ndone",   e_ndone, 1);
        check_val("t6_busy_c3", e_busy_l[3], 0);
        check_val("t6_v_c3",    e_v_l[3], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
